// File: rtl/io_ready_pkg.sv
// Shared types and address decode for the I/O ready checker.
package io_ready_pkg;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        RESERVED = 2'd1,
        FULL     = 2'd2
    } out_state_t;

    // True when addr lands on the port at offset 'port' from 'base'.
    function automatic logic addr_selects(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] port);
        return addr == (base + port);
    endfunction

endpackage

// File: rtl/io_output_port.sv
// One output port: EMPTY -> RESERVED -> FULL -> EMPTY with a one-word buffer.
module io_output_port
    import io_ready_pkg::*;
#(
    parameter int WORD_WIDTH = 36
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  reserve,
    input  logic [WORD_WIDTH-1:0] write_data,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  is_empty
);

    out_state_t state;
    out_state_t state_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= EMPTY;
            out_data <= '0;
        end else begin
            state <= state_next;
            // The result word arrives the cycle after the reservation.
            if (state == RESERVED) begin
                out_data <= write_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        is_empty   = 1'b0;
        case (state)
            EMPTY: begin
                is_empty = 1'b1;
                if (reserve) begin
                    state_next = RESERVED;
                end
            end
            RESERVED: begin
                state_next = FULL;
            end
            FULL: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/io_ready_check.sv
// Registers IO_ready for memory-mapped I/O operands and manages port buffers.
// Optional feature: define IO_READY_STALL_COUNT_EN to add the stall_count output.
module io_ready_check
    import io_ready_pkg::*;
#(
    parameter int ADDR_WIDTH    = 10,
    parameter int WORD_WIDTH    = 36,
    parameter int PORT_COUNT    = 4,
    parameter int IN_BASE_ADDR  = 1020,
    parameter int OUT_BASE_ADDR = 1020
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic [ADDR_WIDTH-1:0]            A_read_addr,
    input  logic [ADDR_WIDTH-1:0]            B_read_addr,
    input  logic [ADDR_WIDTH-1:0]            D_write_addr,
    input  logic [WORD_WIDTH-1:0]            write_data,
    output logic                             IO_ready,
    output logic [WORD_WIDTH-1:0]            A_port_data,
    output logic [WORD_WIDTH-1:0]            B_port_data,
    input  logic [PORT_COUNT*WORD_WIDTH-1:0] in_data,
    input  logic [PORT_COUNT-1:0]            in_valid,
    output logic [PORT_COUNT-1:0]            in_ready,
    output logic [PORT_COUNT*WORD_WIDTH-1:0] out_data,
    output logic [PORT_COUNT-1:0]            out_valid,
    input  logic [PORT_COUNT-1:0]            out_ready
`ifdef IO_READY_STALL_COUNT_EN
    ,
    output logic [31:0]                      stall_count
`endif
);

    logic [PORT_COUNT-1:0] a_sel;
    logic [PORT_COUNT-1:0] b_sel;
    logic [PORT_COUNT-1:0] d_sel;
    logic [PORT_COUNT-1:0] in_sel;
    logic [PORT_COUNT-1:0] in_full;
    logic [PORT_COUNT-1:0] out_empty;
    logic [WORD_WIDTH-1:0] in_buf [PORT_COUNT];
    logic [WORD_WIDTH-1:0] a_word;
    logic [WORD_WIDTH-1:0] b_word;
    logic                  ready_next;

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_decode
        assign a_sel[i] = addr_selects(32'(A_read_addr), 32'(IN_BASE_ADDR), 32'(i));
        assign b_sel[i] = addr_selects(32'(B_read_addr), 32'(IN_BASE_ADDR), 32'(i));
        assign d_sel[i] = addr_selects(32'(D_write_addr), 32'(OUT_BASE_ADDR), 32'(i));
    end

    // A and B on the same port collapse to one consume via the OR.
    assign in_sel     = a_sel | b_sel;
    assign ready_next = (&(~in_sel | in_full)) && (&(~d_sel | out_empty));
    assign in_ready   = ~in_full;

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (a_sel[i]) begin
                a_word |= in_buf[i];
            end
            if (b_sel[i]) begin
                b_word |= in_buf[i];
            end
        end
    end

    // Fill and consume are exclusive: fill needs empty, consume needs full.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            in_full <= '0;
            for (int i = 0; i < PORT_COUNT; i++) begin
                in_buf[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PORT_COUNT; i++) begin
                if (in_valid[i] && !in_full[i]) begin
                    in_full[i] <= 1'b1;
                    in_buf[i]  <= in_data[i*WORD_WIDTH +: WORD_WIDTH];
                end else if (ready_next && in_sel[i]) begin
                    in_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            IO_ready    <= 1'b0;
            A_port_data <= '0;
            B_port_data <= '0;
        end else begin
            IO_ready <= ready_next;
            if (ready_next && (|a_sel)) begin
                A_port_data <= a_word;
            end
            if (ready_next && (|b_sel)) begin
                B_port_data <= b_word;
            end
        end
    end

    for (genvar i = 0; i < PORT_COUNT; i++) begin : g_out_port
        io_output_port #(
            .WORD_WIDTH(WORD_WIDTH)
        ) u_port (
            .clock     (clock),
            .reset_n   (reset_n),
            .reserve   (ready_next && d_sel[i]),
            .write_data(write_data),
            .out_ready (out_ready[i]),
            .out_data  (out_data[i*WORD_WIDTH +: WORD_WIDTH]),
            .out_valid (out_valid[i]),
            .is_empty  (out_empty[i])
        );
    end

`ifdef IO_READY_STALL_COUNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (!ready_next && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_io_ready_check.sv
// Directed self-checking bench for io_ready_check (default build, 4 ports of 36 bits).
module tb_io_ready_check;

    localparam int AW = 10;
    localparam int WW = 36;
    localparam int PC = 4;

    logic              clock;
    logic              reset_n;
    logic [AW-1:0]     A_read_addr;
    logic [AW-1:0]     B_read_addr;
    logic [AW-1:0]     D_write_addr;
    logic [WW-1:0]     write_data;
    logic              IO_ready;
    logic [WW-1:0]     A_port_data;
    logic [WW-1:0]     B_port_data;
    logic [PC*WW-1:0]  in_data;
    logic [PC-1:0]     in_valid;
    logic [PC-1:0]     in_ready;
    logic [PC*WW-1:0]  out_data;
    logic [PC-1:0]     out_valid;
    logic [PC-1:0]     out_ready;
`ifdef IO_READY_STALL_COUNT_EN
    logic [31:0]       stall_count;
`endif

    int tests_run;
    int tests_failed;

    io_ready_check dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .A_read_addr (A_read_addr),
        .B_read_addr (B_read_addr),
        .D_write_addr(D_write_addr),
        .write_data  (write_data),
        .IO_ready    (IO_ready),
        .A_port_data (A_port_data),
        .B_port_data (B_port_data),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
`ifdef IO_READY_STALL_COUNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_io_ready: got %b want 0", IO_ready); end
        tests_run++; if (A_port_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_a_data: got %h want 0", A_port_data); end
        tests_run++; if (B_port_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_b_data: got %h want 0", B_port_data); end
        tests_run++; if (in_ready !== 4'b1111) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 1111", in_ready); end
        tests_run++; if (out_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reset_out_valid: got %b want 0000", out_valid); end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_input_empty();
        A_read_addr = 10'd1020;
        tick();
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL empty_in_stall: got %b want 0", IO_ready); end
        tests_run++; if (in_ready !== 4'b1111) begin tests_failed++; $display("[TB] FAIL empty_in_ready: got %b want 1111", in_ready); end
        A_read_addr = 10'd0;
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL non_io_ready: got %b want 1", IO_ready); end
        tests_run++; if (A_port_data !== '0) begin tests_failed++; $display("[TB] FAIL non_io_a_hold: got %h want 0", A_port_data); end
    endtask

    task automatic test_input_consume();
        in_data = '0;
        in_data[0*WW +: WW] = 36'h5A;
        in_valid = 4'b0001;
        tick();
        in_valid = 4'b0000;
        tests_run++; if (in_ready !== 4'b1110) begin tests_failed++; $display("[TB] FAIL fill_in_ready: got %b want 1110", in_ready); end
        A_read_addr = 10'd1020;
        B_read_addr = 10'd1020;
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL same_port_ready: got %b want 1", IO_ready); end
        tests_run++; if (A_port_data !== 36'h5A) begin tests_failed++; $display("[TB] FAIL same_port_a: got %h want 5a", A_port_data); end
        tests_run++; if (B_port_data !== 36'h5A) begin tests_failed++; $display("[TB] FAIL same_port_b: got %h want 5a", B_port_data); end
        tests_run++; if (in_ready !== 4'b1111) begin tests_failed++; $display("[TB] FAIL consumed_in_ready: got %b want 1111", in_ready); end
        // Consumed only once: a repeat must stall and keep the old data.
        tick();
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reread_stall: got %b want 0", IO_ready); end
        tests_run++; if (A_port_data !== 36'h5A) begin tests_failed++; $display("[TB] FAIL reread_a_hold: got %h want 5a", A_port_data); end
        A_read_addr = 10'd0;
        B_read_addr = 10'd0;
        tick();
    endtask

    task automatic test_two_ports();
        in_data = '0;
        in_data[2*WW +: WW] = 36'h111;
        in_data[3*WW +: WW] = 36'h222;
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b0000;
        A_read_addr = 10'd1022;
        B_read_addr = 10'd1023;
        tick();
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL partial_stall: got %b want 0", IO_ready); end
        tests_run++; if (in_ready !== 4'b1011) begin tests_failed++; $display("[TB] FAIL partial_no_consume: got %b want 1011", in_ready); end
        in_valid = 4'b1000;
        tick();
        in_valid = 4'b0000;
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill_edge_stall: got %b want 0", IO_ready); end
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL two_port_ready: got %b want 1", IO_ready); end
        tests_run++; if (A_port_data !== 36'h111) begin tests_failed++; $display("[TB] FAIL two_port_a: got %h want 111", A_port_data); end
        tests_run++; if (B_port_data !== 36'h222) begin tests_failed++; $display("[TB] FAIL two_port_b: got %h want 222", B_port_data); end
        tests_run++; if (in_ready !== 4'b1111) begin tests_failed++; $display("[TB] FAIL two_port_in_ready: got %b want 1111", in_ready); end
        A_read_addr = 10'd1019;
        B_read_addr = 10'd0;
        D_write_addr = 10'd1019;
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL below_base_ready: got %b want 1", IO_ready); end
        tests_run++; if (A_port_data !== 36'h111) begin tests_failed++; $display("[TB] FAIL below_base_a_hold: got %h want 111", A_port_data); end
        A_read_addr = 10'd0;
        D_write_addr = 10'd0;
    endtask

    task automatic test_output_write();
        D_write_addr = 10'd1021;
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reserve_ready: got %b want 1", IO_ready); end
        tests_run++; if (out_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL reserved_not_valid: got %b want 0000", out_valid); end
        D_write_addr = 10'd0;
        write_data = 36'h123;
        tick();
        write_data = '0;
        tests_run++; if (out_valid !== 4'b0010) begin tests_failed++; $display("[TB] FAIL full_valid: got %b want 0010", out_valid); end
        tests_run++; if (out_data[1*WW +: WW] !== 36'h123) begin tests_failed++; $display("[TB] FAIL full_data: got %h want 123", out_data[1*WW +: WW]); end
    endtask

    task automatic test_drain_same_cycle();
        D_write_addr = 10'd1021;
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL no_bypass_stall: got %b want 0", IO_ready); end
        tests_run++; if (out_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL drained_valid: got %b want 0000", out_valid); end
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL retry_ready: got %b want 1", IO_ready); end
        D_write_addr = 10'd0;
        write_data = 36'h77;
        tick();
        write_data = '0;
        tests_run++; if (out_data[1*WW +: WW] !== 36'h77) begin tests_failed++; $display("[TB] FAIL retry_data: got %h want 77", out_data[1*WW +: WW]); end
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
    endtask

    task automatic test_back_to_back();
        D_write_addr = 10'd1021;
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_first_ready: got %b want 1", IO_ready); end
        write_data = 36'hABC;
        tick();
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_second_stall: got %b want 0", IO_ready); end
        tests_run++; if (out_data[1*WW +: WW] !== 36'hABC) begin tests_failed++; $display("[TB] FAIL b2b_data: got %h want abc", out_data[1*WW +: WW]); end
        D_write_addr = 10'd0;
        write_data = 36'h55;
        tick();
        write_data = '0;
        tests_run++; if (out_data[1*WW +: WW] !== 36'hABC) begin tests_failed++; $display("[TB] FAIL full_holds_data: got %h want abc", out_data[1*WW +: WW]); end
        out_ready = 4'b0010;
        tick();
        out_ready = 4'b0000;
    endtask

    task automatic test_reset_reserved();
        D_write_addr = 10'd1022;
        tick();
        tests_run++; if (IO_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_reserve_ready: got %b want 1", IO_ready); end
        D_write_addr = 10'd0;
        reset_n = 1'b0;
        write_data = 36'h999;
        tick();
        tests_run++; if (out_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rr_valid_in_reset: got %b want 0000", out_valid); end
        tests_run++; if (IO_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_io_ready: got %b want 0", IO_ready); end
        tests_run++; if (A_port_data !== '0) begin tests_failed++; $display("[TB] FAIL rr_a_cleared: got %h want 0", A_port_data); end
        reset_n = 1'b1;
        tick();
        write_data = '0;
        tests_run++; if (out_valid !== 4'b0000) begin tests_failed++; $display("[TB] FAIL rr_write_ignored: got %b want 0000", out_valid); end
        tests_run++; if (out_data[2*WW +: WW] !== '0) begin tests_failed++; $display("[TB] FAIL rr_data_zero: got %h want 0", out_data[2*WW +: WW]); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        A_read_addr  = '0;
        B_read_addr  = '0;
        D_write_addr = '0;
        write_data   = '0;
        in_data      = '0;
        in_valid     = '0;
        out_ready    = '0;
        #1;
        test_reset();
        test_input_empty();
        test_input_consume();
        test_two_ports();
        test_output_write();
        test_drain_same_cycle();
        test_back_to_back();
        test_reset_reserved();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
